// File: rtl/timer_irq_unit.sv
// rtl/timer_irq_unit.sv - memory-mapped 32-bit interval timer with sticky overflow interrupt
// TH reload, TL counter and TCON {IS,IE,EN} sit at BASE_ADDR, +4, +8 on the CPU data bus.
module timer_irq_unit #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        rd,
   input  logic        wr,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic        is_q, is_d;
   logic [15:0] presc_q, presc_d;

   logic sel_th, sel_tl, sel_tcon;
   logic wr_th, wr_tl, wr_tcon;
   logic tick, ovf;

   assign sel_th   = (addr == BASE_ADDR);
   assign sel_tl   = (addr == BASE_ADDR + 32'd4);
   assign sel_tcon = (addr == BASE_ADDR + 32'd8);

   assign wr_th   = wr & sel_th;
   assign wr_tl   = wr & sel_tl;
   assign wr_tcon = wr & sel_tcon;

   assign tick = en_q & (presc_q == PS_LAST);
   // A TL write consumes the tick, so it can neither reload nor flag an overflow.
   assign ovf  = tick & ~wr_tl & (tl_q == 32'hFFFF_FFFF);

   always_comb begin
      th_d    = th_q;
      tl_d    = tl_q;
      en_d    = en_q;
      ie_d    = ie_q;
      is_d    = is_q;
      presc_d = presc_q;

      if (!en_q || tick) begin
         presc_d = 16'd0;
      end else begin
         presc_d = presc_q + 16'd1;
      end

      if (ovf) begin
         tl_d = th_q;
         if (ie_q) begin
            is_d = 1'b1;
         end
      end else if (tick) begin
         tl_d = tl_q + 32'd1;
      end

      if (wr_th) begin
         th_d = wdata;
      end
      if (wr_tl) begin
         tl_d = wdata;
      end
      // An overflow landing on a TCON write must not be cleared by it.
      if (wr_tcon) begin
         en_d = wdata[0];
         ie_d = wdata[1];
         is_d = wdata[2] | (ovf & ie_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         th_q    <= '0;
         tl_q    <= '0;
         en_q    <= 1'b0;
         ie_q    <= 1'b0;
         is_q    <= 1'b0;
         presc_q <= '0;
      end else begin
         th_q    <= th_d;
         tl_q    <= tl_d;
         en_q    <= en_d;
         ie_q    <= ie_d;
         is_q    <= is_d;
         presc_q <= presc_d;
      end
   end

   always_comb begin
      rdata = '0;
      if (rd) begin
         if (sel_th) begin
            rdata = th_q;
         end else if (sel_tl) begin
            rdata = tl_q;
         end else if (sel_tcon) begin
            rdata = {29'd0, is_q, ie_q, en_q};
         end
      end
   end

   assign irq = is_q & ie_q;

endmodule
